mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Memory controller between the CPU pipeline and the single byte-wide synchronous RAM.
- Feeds the fetch path (fills the instruction word the IF/ID register consumes) and serves the MEM stage's loads and stores.
- Arbitrates the two requesters and serializes each 32-bit or sub-word access into little-endian byte transfers.
- Assembles read bytes into a word and pulses a one-cycle done to the owning requester.

Parameters:
RAM_AW, 17, width of the RAM byte address; ram_addr_o carries the low RAM_AW bits of the request address.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; synchronous and active-high
if_req_i  in  1  instruction fetch request; held high until if_done_o or cancel
if_addr_i  in  32  fetch byte address; fetches are always 4 bytes
if_cancel_i  in  1  abort in-flight or pending fetch (branch redirect)
if_data_o  out  32  fetched instruction word
if_done_o  out  1  one-cycle pulse: if_data_o valid
mem_req_i  in  1  data access request; held high until mem_done_o
mem_we_i  in  1  1 = store, 0 = load
mem_addr_i  in  32  data byte address
mem_len_i  in  2  00 = 1 byte, 01 = 2 bytes, 10/11 = 4 bytes
mem_wdata_i  in  32  store data; byte k = bits [8k+7:8k]
mem_rdata_o  out  32  load data, zero-extended; sign extension is the MEM stage's job
mem_done_o  out  1  one-cycle pulse: access complete
ram_addr_o  out  RAM_AW  RAM byte address (registered)
ram_wr_o  out  1  RAM write enable (registered)
ram_dout_o  out  8  RAM write data (registered)
ram_din_i  in  8  RAM read data; valid one cycle after the RAM samples the address

Behaviour:
- States: IDLE, XFER, DONE.
- Reset: state = IDLE. All outputs are 0: ram_addr_o, ram_wr_o, ram_dout_o, if_data_o, mem_rdata_o, if_done_o, mem_done_o.
- Reset mid-transfer: the access is abandoned at that edge, ram_wr_o drops, and no done pulse is issued. A partial store remains partial.

IDLE:
- Requests are sampled each edge.
- mem_req_i has priority over if_req_i. With both high, the MEM access is accepted and IF waits.
- if_req_i together with if_cancel_i in the same cycle is not accepted.
- On accept (edge E0), the controller latches owner, address, we, nbytes (1/2/4) and wdata, and sets cnt = 0.
- At E0 it also registers ram_addr_o = addr, ram_wr_o = we, ram_dout_o = wdata[7:0], then enters XFER.

XFER, write:
- At edges E1..E(n-1), it drives ram_addr_o = addr+k, ram_dout_o = byte k, ram_wr_o = 1.
- At edge En, ram_wr_o goes to 0 and the state becomes DONE.

XFER, read:
- At edges E1..E(n-1), it drives ram_addr_o = addr+k, ram_wr_o = 0.
- Byte k is captured from ram_din_i at edge E(k+2) into bits [8k+7:8k]. Unused high bytes are cleared to 0.
- After capturing the last byte at E(n+1), the state becomes DONE.

DONE:
- The owner's done output is 1 for exactly this one cycle.
- The owner's data register is updated at the edge entering DONE and holds until that port's next done.
- No request is sampled in DONE. Next edge goes to IDLE, so a requester that drops req on seeing done is never re-accepted.

Latency (request high before E0 to the done cycle):
- Word read: done in the cycle after E5, i.e. 6 cycles.
- Byte read: 3 cycles.
- Word write: 5 cycles.
- Byte write: 2 cycles.

Address arithmetic:
- addr+k wraps modulo 2^RAM_AW.
- Unaligned accesses are legal and simply byte-serialized.

if_cancel_i:
- Owner IF in XFER: return to IDLE at the next edge, with no if_done_o and no if_data_o update.
- Owner MEM: ignored.
- In DONE with owner IF: if_done_o is suppressed.

Other rules:
- Requester inputs other than if_cancel_i are only sampled at acceptance; changes mid-transfer are ignored.
- ram_wr_o is never 1 outside XFER.

Test Plan:
- Reset then if_req_i = 1, if_addr_i = 0x10, RAM[0x10..0x13] = 13,05,10,00 -> ram_addr_o steps 0x10..0x13; if_data_o = 0x00100513 with if_done_o high for 1 cycle, 6 cycles after the request.
- Store mem_we_i = 1, mem_len_i = 01, addr 0x1FFFF, wdata 0xAABBCCDD, RAM_AW = 17 -> writes 0xDD @0x1FFFF then 0xCC @0x00000 (wrap); ram_wr_o high for exactly 2 cycles; mem_done_o pulse next cycle.
- mem_req_i and if_req_i rise together (load byte @0x4, RAM = 0x80) -> MEM served first, mem_rdata_o = 0x00000080; the fetch is accepted on the cycle after mem_done_o.
- Word fetch with if_cancel_i pulsed during the third XFER cycle -> no if_done_o, if_data_o keeps its old value, and the controller is back in IDLE one edge later.
- Reset asserted during the second byte of a word store -> ram_wr_o = 0 at that edge, all outputs 0, no mem_done_o; a new request after reset proceeds normally.
- Requester holds mem_req_i high one cycle past mem_done_o -> exactly one access is performed per request, with no duplicate transfer.

Source files
------------

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates instruction fetch and MEM-stage accesses onto
// a byte-wide synchronous RAM, serializing each access into little-endian
// byte transfers and assembling read bytes back into a 32-bit word.
module mem_ctrl #(
  parameter int RAM_AW = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  input  logic              if_cancel_i,
  output logic [31:0]       if_data_o,
  output logic              if_done_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [1:0]        mem_len_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_done_o,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic              ram_wr_o,
  output logic [7:0]        ram_dout_o,
  input  logic [7:0]        ram_din_i
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t            state, state_next;

  // Access context latched at acceptance.
  logic              owner_mem;
  logic [RAM_AW-1:0] base;
  logic              we;
  logic [2:0]        nbytes;
  logic [31:0]       wdata;
  logic [2:0]        cnt;
  logic [31:0]       rbuf;

  // step is the index of the edge about to happen, counted from acceptance (E0).
  logic [2:0]        step;
  logic [1:0]        wr_idx;
  logic [1:0]        cap_idx;
  logic              accept_mem, accept_if, issue, capture, finish, abort;
  logic [31:0]       rbuf_next;
  logic [2:0]        len_bytes;

  assign step    = cnt + 3'd1;
  assign wr_idx  = step[1:0];
  // Byte k returns two edges after its address is registered.
  assign cap_idx = step[1:0] - 2'd2;

  assign len_bytes = (mem_len_i == 2'b00) ? 3'd1 :
                     (mem_len_i == 2'b01) ? 3'd2 : 3'd4;

  // Done pulses are decoded from the state; a fetch cancelled in DONE gets none.
  assign if_done_o  = (state == DONE) && !owner_mem && !if_cancel_i;
  assign mem_done_o = (state == DONE) && owner_mem;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    // NOTE: reset is synchronous: sampled only on the rising edge.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and per-edge control decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_next = state;
    accept_mem = 1'b0;
    accept_if  = 1'b0;
    issue      = 1'b0;
    capture    = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req_i) begin
          accept_mem = 1'b1;
          state_next = XFER;
        end else if (if_req_i && !if_cancel_i) begin
          accept_if  = 1'b1;
          state_next = XFER;
        end
      end
      XFER: begin
        if (!owner_mem && if_cancel_i) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (we) begin
          issue = (step < nbytes);
          if (!issue) begin
            finish     = 1'b1;
            state_next = DONE;
          end
        end else begin
          issue   = (step < nbytes);
          capture = (step >= 3'd2);
          if (step == nbytes + 3'd1) begin
            finish     = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read assembly: merge the returning byte into its lane.
  always_comb begin
    rbuf_next = rbuf;
    if (capture) rbuf_next[8*cap_idx +: 8] = ram_din_i;
  end

  // Datapath: access context, RAM interface registers and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_mem   <= 1'b0;
      base        <= '0;
      we          <= 1'b0;
      nbytes      <= 3'd0;
      wdata       <= 32'd0;
      cnt         <= 3'd0;
      rbuf        <= 32'd0;
      ram_addr_o  <= '0;
      ram_wr_o    <= 1'b0;
      ram_dout_o  <= 8'd0;
      if_data_o   <= 32'd0;
      mem_rdata_o <= 32'd0;
    end else begin
      ram_wr_o <= 1'b0;
      if (accept_mem || accept_if) begin
        owner_mem  <= accept_mem;
        base       <= accept_mem ? mem_addr_i[RAM_AW-1:0] : if_addr_i[RAM_AW-1:0];
        we         <= accept_mem && mem_we_i;
        nbytes     <= accept_mem ? len_bytes : 3'd4;
        wdata      <= accept_mem ? mem_wdata_i : 32'd0;
        cnt        <= 3'd0;
        rbuf       <= 32'd0;
        ram_addr_o <= accept_mem ? mem_addr_i[RAM_AW-1:0] : if_addr_i[RAM_AW-1:0];
        ram_wr_o   <= accept_mem && mem_we_i;
        ram_dout_o <= accept_mem ? mem_wdata_i[7:0] : 8'd0;
      end
      if (state == XFER && !abort) begin
        cnt  <= step;
        rbuf <= rbuf_next;
        if (issue) begin
          // Address arithmetic wraps naturally at RAM_AW bits.
          ram_addr_o <= base + RAM_AW'(step);
          ram_dout_o <= wdata[8*wr_idx +: 8];
          ram_wr_o   <= we;
        end
      end
      if (finish && !we) begin
        if (owner_mem) mem_rdata_o <= rbuf_next;
        else           if_data_o   <= rbuf_next;
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a behavioural byte-wide synchronous RAM.
module tb_mem_ctrl;

  localparam int RAM_AW = 17;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req_i, if_cancel_i, if_done_o;
  logic [31:0]       if_addr_i, if_data_o;
  logic              mem_req_i, mem_we_i, mem_done_o;
  logic [31:0]       mem_addr_i, mem_wdata_i, mem_rdata_o;
  logic [1:0]        mem_len_i;
  logic [RAM_AW-1:0] ram_addr_o;
  logic              ram_wr_o;
  logic [7:0]        ram_dout_o, ram_din_i;

  mem_ctrl #(.RAM_AW(RAM_AW)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_cancel_i(if_cancel_i),
    .if_data_o(if_data_o), .if_done_o(if_done_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_len_i(mem_len_i), .mem_wdata_i(mem_wdata_i),
    .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o),
    .ram_addr_o(ram_addr_o), .ram_wr_o(ram_wr_o), .ram_dout_o(ram_dout_o),
    .ram_din_i(ram_din_i)
  );

  always #5 clk = ~clk;

  // RAM model: read-before-write, data one cycle after the address is sampled.
  logic [7:0]        ram [0:(1<<RAM_AW)-1];
  logic              pl_en = 1'b0;
  logic [RAM_AW-1:0] pl_addr = '0;
  logic [7:0]        pl_data = 8'd0;

  always @(posedge clk) begin
    if (pl_en)         ram[pl_addr]    <= pl_data;
    else if (ram_wr_o) ram[ram_addr_o] <= ram_dout_o;
    ram_din_i <= ram[ram_addr_o];
  end

  // Event counters observed away from the active edge.
  int if_done_cnt = 0, mem_done_cnt = 0, wr_total = 0;
  always @(negedge clk) begin
    if (if_done_o)  if_done_cnt++;
    if (mem_done_o) mem_done_cnt++;
    if (ram_wr_o)   wr_total++;
  end

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [RAM_AW-1:0] a, input logic [7:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // Per-transaction trace gathered while waiting for a done pulse.
  logic [RAM_AW-1:0] trace [0:31];
  logic [RAM_AW-1:0] wr_addr [0:7];
  logic [7:0]        wr_data [0:7];
  int                nwr;

  // Returns the number of negedges after the request until done (0 = timeout).
  task automatic wait_done(input bit is_mem, input int limit, output int cyc);
    cyc = 0;
    nwr = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      trace[i] = ram_addr_o;
      if (ram_wr_o && nwr < 8) begin
        wr_addr[nwr] = ram_addr_o;
        wr_data[nwr] = ram_dout_o;
        nwr++;
      end
      if (is_mem ? mem_done_o : if_done_o) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ram_addr"},  32'(ram_addr_o), 32'd0);
    check({tag, " ram_wr"},    32'(ram_wr_o),   32'd0);
    check({tag, " ram_dout"},  32'(ram_dout_o), 32'd0);
    check({tag, " if_data"},   if_data_o,       32'd0);
    check({tag, " mem_rdata"}, mem_rdata_o,     32'd0);
    check({tag, " if_done"},   32'(if_done_o),  32'd0);
    check({tag, " mem_done"},  32'(mem_done_o), 32'd0);
  endtask

  task automatic mem_start(input bit w, input logic [1:0] len,
                           input logic [31:0] a, input logic [31:0] d);
    mem_req_i   = 1'b1;
    mem_we_i    = w;
    mem_len_i   = len;
    mem_addr_i  = a;
    mem_wdata_i = d;
  endtask

  int cyc, base_cnt, base_wr;

  initial begin
    rst = 1'b1;
    if_req_i = 0; if_cancel_i = 0; if_addr_i = 0;
    mem_req_i = 0; mem_we_i = 0; mem_addr_i = 0; mem_len_i = 0; mem_wdata_i = 0;

    // Preload RAM while reset is held.
    poke(17'h10, 8'h13); poke(17'h11, 8'h05); poke(17'h12, 8'h10); poke(17'h13, 8'h00);
    poke(17'h20, 8'h11); poke(17'h21, 8'h22); poke(17'h22, 8'h33); poke(17'h23, 8'h44);
    poke(17'h30, 8'hEF); poke(17'h31, 8'hAD); poke(17'h32, 8'hBE); poke(17'h33, 8'hDE);
    poke(17'h04, 8'h80);
    poke(17'h100, 8'h00); poke(17'h101, 8'h00); poke(17'h102, 8'h00); poke(17'h103, 8'h00);
    poke(17'h1FFFF, 8'h00); poke(17'h0, 8'h00); poke(17'h200, 8'h00);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Word fetch from 0x10.
    @(negedge clk);
    if_req_i = 1; if_addr_i = 32'h10;
    wait_done(0, 20, cyc);
    if_req_i = 0;
    check("fetch latency", cyc, 6);
    for (int k = 0; k < 4; k++) check("fetch addr step", 32'(trace[k+1]), 32'h10 + k);
    check("fetch data", if_data_o, 32'h00100513);
    @(negedge clk);
    check("fetch done one cycle", 32'(if_done_o), 32'd0);

    // Halfword store wrapping at the top of the RAM.
    mem_start(1, 2'b01, 32'h0001FFFF, 32'hAABBCCDD);
    wait_done(1, 20, cyc);
    mem_req_i = 0;
    check("store2 latency", cyc, 3);
    check("store2 write cycles", nwr, 2);
    check("store2 wr0 addr", 32'(wr_addr[0]), 32'h1FFFF);
    check("store2 wr0 data", 32'(wr_data[0]), 32'hDD);
    check("store2 wr1 addr", 32'(wr_addr[1]), 32'h00000);
    check("store2 wr1 data", 32'(wr_data[1]), 32'hCC);
    check("store2 ram top", 32'(ram[17'h1FFFF]), 32'hDD);
    check("store2 ram zero", 32'(ram[17'h0]), 32'hCC);

    // Word load, leaves high bytes set in mem_rdata_o.
    @(negedge clk);
    mem_start(0, 2'b10, 32'h20, 32'h0);
    wait_done(1, 20, cyc);
    mem_req_i = 0;
    check("load4 latency", cyc, 6);
    check("load4 data", mem_rdata_o, 32'h44332211);
    check("if_data held", if_data_o, 32'h00100513);

    // Simultaneous requests: byte load wins, fetch follows.
    @(negedge clk);
    mem_start(0, 2'b00, 32'h4, 32'h0);
    if_req_i = 1; if_addr_i = 32'h20;
    wait_done(1, 20, cyc);
    mem_req_i = 0;
    check("arb load1 latency", cyc, 3);
    check("arb load1 zero-ext", mem_rdata_o, 32'h00000080);
    wait_done(0, 20, cyc);
    if_req_i = 0;
    check("arb fetch wait idle", 32'(trace[1]), 32'h4);
    check("arb fetch accepted", 32'(trace[2]), 32'h20);
    check("arb fetch latency", cyc, 7);
    check("arb fetch data", if_data_o, 32'h44332211);

    // Fetch cancelled in its third XFER cycle.
    @(negedge clk);
    #1 base_cnt = if_done_cnt;
    if_req_i = 1; if_addr_i = 32'h30;
    repeat (3) @(negedge clk);
    check("cancel addr before", 32'(ram_addr_o), 32'h32);
    if_cancel_i = 1; if_req_i = 0;
    @(negedge clk);
    if_cancel_i = 0;
    check("cancel no further issue", 32'(ram_addr_o), 32'h32);
    mem_start(0, 2'b00, 32'h31, 32'h0);
    wait_done(1, 20, cyc);
    mem_req_i = 0;
    check("cancel idle accept", 32'(trace[1]), 32'h31);
    check("post-cancel load latency", cyc, 3);
    check("post-cancel load data", mem_rdata_o, 32'h000000AD);
    repeat (6) @(negedge clk);
    #1;
    check("cancel no if_done", if_done_cnt, base_cnt);
    check("cancel if_data kept", if_data_o, 32'h44332211);

    // Reset during the second byte of a word store.
    #1 base_cnt = mem_done_cnt;
    @(negedge clk);
    mem_start(1, 2'b10, 32'h100, 32'h12345678);
    @(negedge clk);
    check("rst store b0 wr", 32'(ram_wr_o), 32'd1);
    check("rst store b0 data", 32'(ram_dout_o), 32'h78);
    @(negedge clk);
    check("rst store b1 addr", 32'(ram_addr_o), 32'h101);
    rst = 1; mem_req_i = 0;
    @(negedge clk);
    check_all_zero("mid reset");
    rst = 0;
    check("partial ram 100", 32'(ram[17'h100]), 32'h78);
    check("partial ram 101", 32'(ram[17'h101]), 32'h56);
    check("partial ram 102", 32'(ram[17'h102]), 32'h00);
    mem_start(0, 2'b00, 32'h101, 32'h0);
    wait_done(1, 20, cyc);
    mem_req_i = 0;
    check("after reset latency", cyc, 3);
    check("after reset data", mem_rdata_o, 32'h00000056);
    #1 check("reset no mem_done", mem_done_cnt, base_cnt + 1);

    // Requester holds mem_req_i one edge past done: a single access only.
    @(negedge clk);
    #1 begin base_cnt = mem_done_cnt; base_wr = wr_total; end
    mem_start(1, 2'b00, 32'h200, 32'h0000005A);
    wait_done(1, 20, cyc);
    check("store1 latency", cyc, 2);
    @(negedge clk);
    mem_req_i = 0;
    repeat (8) @(negedge clk);
    #1;
    check("hold one access", mem_done_cnt, base_cnt + 1);
    check("hold one write", wr_total, base_wr + 1);
    check("hold ram data", 32'(ram[17'h200]), 32'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
